// File: rtl/timer_irq.sv
// -----------------------------------------------------------------------------
// timer_irq
// CPU-mapped down-counting timer with prescaler, one-shot / auto-reload modes
// and a level, active-low interrupt output.
//
// Ports
//   clk_i       in   1  system clock (shared with the CPU)
//   rst_i       in   1  synchronous active-high reset
//   R_W_n       in   1  CPU strobe: 1 = read, 0 = write
//   timer_cs    in   1  IO-page select from the address decoder
//   reg_addr_i  in   3  register index (cpu_addr[2:0])
//   data_i      in   8  CPU write data
//   data_o      out  8  read data, combinational from state and reg_addr_i
//   irq_n       out  1  active-low interrupt, registered
//
// Register map
//   0 CTRL      b0 EN, b1 AUTO, b2 IRQEN, b3 LOAD (strobe, reads 0)
//   1 STATUS    b0 FLAG (write 1 to clear), b1 RUN (= EN, read-only)
//   2 RELOAD_L  3 RELOAD_H
//   4 COUNT_L   read also latches COUNT[15:8] into the snapshot
//   5 COUNT_H   returns the snapshot
//   6 PRESCALE  lower PRESCALE_W bits
//   7 reserved  reads 0, writes ignored
// -----------------------------------------------------------------------------
module timer_irq #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       R_W_n,
   input  logic       timer_cs,
   input  logic [2:0] reg_addr_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       irq_n
);

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned COUNT_W = 16;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_STATUS   = 3'd1;
   localparam logic [2:0] ADDR_RELOAD_L = 3'd2;
   localparam logic [2:0] ADDR_RELOAD_H = 3'd3;
   localparam logic [2:0] ADDR_COUNT_L  = 3'd4;
   localparam logic [2:0] ADDR_COUNT_H  = 3'd5;
   localparam logic [2:0] ADDR_PRESCALE = 3'd6;

   // ---------------------------------------------------------------- state
   logic                  r_en;
   logic                  r_auto;
   logic                  r_irqen;
   logic                  r_flag;
   logic [COUNT_W-1:0]    r_reload;
   logic [COUNT_W-1:0]    r_count;
   logic [DATA_W-1:0]     r_snap;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [PRESCALE_W-1:0] r_pc;
   logic                  r_irq_n;

   // ------------------------------------------------------- next-state nets
   logic                  w_en_nxt;
   logic                  w_auto_nxt;
   logic                  w_irqen_nxt;
   logic                  w_flag_nxt;
   logic [COUNT_W-1:0]    w_reload_nxt;
   logic [COUNT_W-1:0]    w_count_nxt;
   logic [DATA_W-1:0]     w_snap_nxt;
   logic [PRESCALE_W-1:0] w_prescale_nxt;
   logic [PRESCALE_W-1:0] w_pc_nxt;
   logic                  w_irq_n_nxt;

   // ------------------------------------------------------- bus decode
   logic w_wr;
   logic w_rd;
   logic w_wr_ctrl;
   logic w_wr_status;
   logic w_wr_reload_l;
   logic w_wr_reload_h;
   logic w_wr_prescale;
   logic w_rd_count_l;
   logic w_load;
   logic w_ctrl_disable;

   assign w_wr           = timer_cs & ~R_W_n;
   assign w_rd           = timer_cs &  R_W_n;
   assign w_wr_ctrl      = w_wr & (reg_addr_i == ADDR_CTRL);
   assign w_wr_status    = w_wr & (reg_addr_i == ADDR_STATUS);
   assign w_wr_reload_l  = w_wr & (reg_addr_i == ADDR_RELOAD_L);
   assign w_wr_reload_h  = w_wr & (reg_addr_i == ADDR_RELOAD_H);
   assign w_wr_prescale  = w_wr & (reg_addr_i == ADDR_PRESCALE);
   assign w_rd_count_l   = w_rd & (reg_addr_i == ADDR_COUNT_L);
   assign w_load         = w_wr_ctrl &  data_i[3];
   assign w_ctrl_disable = w_wr_ctrl & ~data_i[0];

   // ------------------------------------------------------- tick / underflow
   logic w_tick;
   logic w_tick_eff;
   logic w_count_zero;
   logic w_underflow;

   assign w_tick       = r_en & (r_pc == r_prescale);
   // A load or a disabling CTRL write on the same edge swallows the tick.
   assign w_tick_eff   = w_tick & ~w_load & ~w_ctrl_disable;
   assign w_count_zero = (r_count == '0);
   assign w_underflow  = w_tick_eff & w_count_zero;

   // Next-state logic for all timer registers.
   always_comb begin
      w_en_nxt       = r_en;
      w_auto_nxt     = r_auto;
      w_irqen_nxt    = r_irqen;
      w_flag_nxt     = r_flag;
      w_reload_nxt   = r_reload;
      w_count_nxt    = r_count;
      w_snap_nxt     = r_snap;
      w_prescale_nxt = r_prescale;
      w_pc_nxt       = r_pc;
      w_irq_n_nxt    = ~(r_flag & r_irqen);

      // register writes
      if (w_wr_ctrl) begin
         w_en_nxt    = data_i[0];
         w_auto_nxt  = data_i[1];
         w_irqen_nxt = data_i[2];
      end
      if (w_wr_reload_l) begin
         w_reload_nxt[7:0] = data_i;
      end
      if (w_wr_reload_h) begin
         w_reload_nxt[15:8] = data_i;
      end
      if (w_wr_prescale) begin
         w_prescale_nxt = PRESCALE_W'(data_i);
      end

      // COUNT_L read freezes the high byte so a following COUNT_H read is coherent
      if (w_rd_count_l) begin
         w_snap_nxt = r_count[15:8];
      end

      // prescaler
      if (!r_en || w_tick) begin
         w_pc_nxt = '0;
      end else begin
         w_pc_nxt = r_pc + PRESCALE_W'(1);
      end
      if (w_load || w_wr_prescale || w_ctrl_disable) begin
         w_pc_nxt = '0;
      end

      // down-counter
      if (w_load) begin
         w_count_nxt = r_reload;
      end else if (w_tick_eff) begin
         if (!w_count_zero) begin
            w_count_nxt = r_count - COUNT_W'(1);
         end else if (r_auto) begin
            w_count_nxt = r_reload;
         end else begin
            w_en_nxt = 1'b0;
         end
      end

      // set beats clear when both land on the same edge
      if (w_wr_status && data_i[0]) begin
         w_flag_nxt = 1'b0;
      end
      if (w_underflow) begin
         w_flag_nxt = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_irqen    <= 1'b0;
         r_flag     <= 1'b0;
         r_reload   <= '0;
         r_count    <= '0;
         r_snap     <= '0;
         r_prescale <= '0;
         r_pc       <= '0;
         r_irq_n    <= 1'b1;
      end else begin
         r_en       <= w_en_nxt;
         r_auto     <= w_auto_nxt;
         r_irqen    <= w_irqen_nxt;
         r_flag     <= w_flag_nxt;
         r_reload   <= w_reload_nxt;
         r_count    <= w_count_nxt;
         r_snap     <= w_snap_nxt;
         r_prescale <= w_prescale_nxt;
         r_pc       <= w_pc_nxt;
         r_irq_n    <= w_irq_n_nxt;
      end
   end

   // Read mux; deselected bus returns zero.
   logic [DATA_W-1:0] w_rdata;

   always_comb begin
      w_rdata = '0;
      if (timer_cs) begin
         case (reg_addr_i)
            ADDR_CTRL:     w_rdata = {5'b0, r_irqen, r_auto, r_en};
            ADDR_STATUS:   w_rdata = {6'b0, r_en, r_flag};
            ADDR_RELOAD_L: w_rdata = r_reload[7:0];
            ADDR_RELOAD_H: w_rdata = r_reload[15:8];
            ADDR_COUNT_L:  w_rdata = r_count[7:0];
            ADDR_COUNT_H:  w_rdata = r_snap;
            ADDR_PRESCALE: w_rdata = DATA_W'(r_prescale);
            default:       w_rdata = '0;
         endcase
      end
   end

   assign data_o = w_rdata;
   assign irq_n  = r_irq_n;

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 8, width in bits of the prescaler register and counter.
REQ-002 SHALL have port clk_i  input  1  system clock, the same clock as the CPU.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port R_W_n  input  1  CPU read (1) or write (0) strobe.
REQ-005 SHALL have port timer_cs  input  1  IO-page select from the address decoder.
REQ-006 SHALL have port reg_addr_i  input  3  register index taken from cpu_addr[2:0].
REQ-007 SHALL have port data_i  input  8  CPU write data.
REQ-008 SHALL have port data_o  output  8  read data; combinational from register state and reg_addr_i.
REQ-009 SHALL have port irq_n  output  1  active-low interrupt output to the CPU IRQ_n input.

Function
REQ-010 SHALL treat a register write as valid on a rising clk_i edge where timer_cs=1 and R_W_n=0.
REQ-011 SHALL treat a register read as valid on an edge where timer_cs=1 and R_W_n=1; only read side effects happen on that edge.
REQ-012 SHALL implement this register map:
- 0 CTRL rw: b0 EN, b1 AUTO, b2 IRQEN, b3 LOAD (write-only strobe, reads 0), b7..4 read 0.
- 1 STATUS: b0 FLAG (write 1 clears it), b1 RUN = EN (read-only).
- 2 RELOAD_L rw.
- 3 RELOAD_H rw.
- 4 COUNT_L ro: a read also copies COUNT[15:8] into a snapshot register.
- 5 COUNT_H ro: returns the snapshot.
- 6 PRESCALE rw: lower PRESCALE_W bits.
- 7 reserved: reads 0x00, writes ignored.
REQ-013 SHALL run a prescaler counter PC while EN=1: PC increments each clock; when PC==PRESCALE it generates a one-cycle tick and PC returns to 0.
REQ-014 SHALL hold PC at 0 while EN=0.
REQ-015 SHALL, on a tick with COUNT!=0, decrement COUNT by 1.
REQ-016 SHALL, on a tick with COUNT==0, produce an underflow event:
- FLAG is set to 1.
- If AUTO=1: COUNT loads RELOAD.
- If AUTO=0: EN clears and COUNT stays 0.
REQ-017 SHALL give an underflow period of (RELOAD+1)*(PRESCALE+1) clocks, counted from the LOAD strobe.
REQ-018 SHALL, on a CTRL write with LOAD=1, load COUNT from RELOAD and clear PC in that same edge; EN, AUTO and IRQEN take the written values.
REQ-019 SHALL NOT change COUNT when RELOAD_L or RELOAD_H is written; the new value is used only at the next load or reload.
REQ-020 SHALL clear PC when PRESCALE is written.
REQ-021 SHALL drive irq_n = ~(FLAG & IRQEN) from registered state only, so irq_n goes low one clock after the underflow edge.
REQ-022 SHALL resolve simultaneous events as follows:
- STATUS clear write in the same edge as an underflow: FLAG remains 1 (set wins).
- CTRL write with LOAD=1 in the same edge as a tick: the load wins and no decrement or underflow occurs.
- CTRL write with EN=0 in the same edge as a tick: the tick is discarded.
REQ-023 SHALL keep FLAG set while IRQEN=0; setting IRQEN later asserts irq_n immediately (next clock).
REQ-024 SHALL produce data_o=0x00 whenever timer_cs=0.

Reset
REQ-025 SHALL, when rst_i=1 at a clock edge, set CTRL=0, FLAG=0, RELOAD=0x0000, COUNT=0x0000, snapshot=0x00, PRESCALE=0 and PC=0.
REQ-026 SHALL hold irq_n=1 during reset and in the clock after reset.
REQ-027 SHALL abort any in-progress count when reset is asserted mid-operation, with no underflow and no FLAG set in that edge.

Verification
REQ-028 SHALL be verified by a one-shot scenario:
- Stimulus: RELOAD=0x0003, PRESCALE=0, CTRL=0x0D (EN, IRQEN, LOAD).
- Response: FLAG=1 exactly 4 clocks after the write edge; irq_n low the next clock; EN=0; COUNT=0.
REQ-029 SHALL be verified by an auto-reload scenario:
- Stimulus: RELOAD=0x0001, PRESCALE=2, CTRL=0x0B.
- Response: underflows every 6 clocks; irq_n stays 1 because IRQEN=0; FLAG=1.
REQ-030 SHALL be verified by a clear-race scenario:
- Stimulus: write STATUS=0x01 on the same edge as an underflow.
- Response: FLAG=1 and irq_n low. A STATUS=0x01 write one clock later gives FLAG=0 and irq_n=1.
REQ-031 SHALL be verified by a snapshot scenario:
- Stimulus: COUNT=0x0100 running with PRESCALE=0; read COUNT_L, then COUNT_H 3 clocks later.
- Response: the COUNT_H read returns 0x01, not 0x00.
REQ-032 SHALL be verified by a reset-mid-count scenario:
- Stimulus: pulse rst_i with COUNT=0x0002 running.
- Response: all registers are 0, irq_n=1, and no FLAG is set afterwards without a new LOAD.
REQ-033 SHALL be verified by a reserved/deselect scenario:
- Stimulus: read reg 7, and any read with timer_cs=0.
- Response: data_o=0x00 in both cases.
